// File: rtl/la_pkg.sv
// -----------------------------------------------------------------------------
// la_pkg
// Definitions shared by the logic analyzer capture sequencer, the host
// register map and the trigger block.
//   - la_state_t    : capture sequencer states, encoded as seen by the host
//   - SINGLE_SHOT / INCREMENTAL / IMMEDIATE : trigger_mode encodings
//   - ptr_inc()     : modulo-depth pointer increment (depth need not be 2^n)
//   - clamp_loc()   : limits a trigger position to depth-1
//   - sanitize_mode(): maps the reserved mode encoding onto single-shot
// -----------------------------------------------------------------------------
package la_pkg;

    typedef enum logic [2:0] {
        IDLE             = 3'd0,
        MOVE_TO_POSITION = 3'd1,
        IN_POSITION      = 3'd2,
        CAPTURING        = 3'd3,
        CAPTURED         = 3'd4
    } la_state_t;

    typedef logic [1:0] la_mode_t;

    localparam la_mode_t SINGLE_SHOT = 2'd0;
    localparam la_mode_t INCREMENTAL = 2'd1;
    localparam la_mode_t IMMEDIATE   = 2'd2;

    // Next address in a circular buffer of 'depth' entries.
    function automatic int unsigned ptr_inc(input int unsigned ptr,
                                            input int unsigned depth);
        return (ptr + 1 >= depth) ? 0 : ptr + 1;
    endfunction

    // A trigger position can retain at most depth-1 pre-trigger samples,
    // because the trigger sample itself must also fit in the buffer.
    function automatic int unsigned clamp_loc(input int unsigned loc,
                                              input int unsigned depth);
        return (loc > depth - 1) ? depth - 1 : loc;
    endfunction

    // Encoding 3 is reserved and behaves exactly like single-shot.
    function automatic la_mode_t sanitize_mode(input la_mode_t mode);
        return (mode == INCREMENTAL || mode == IMMEDIATE) ? mode : SINGLE_SHOT;
    endfunction

endpackage

// File: rtl/la_capture_fsm_if.sv
// -----------------------------------------------------------------------------
// la_capture_fsm_if
// Bundle between the host/trigger side and the capture sequencer.
//   Parameter SAMPLE_DEPTH must match the sequencer instance it connects to.
//   master : host + trigger comparator side (drives requests, config, trig)
//   slave  : capture sequencer side (drives state, write strobe, pointers)
// Signals:
//   request_start, request_stop  host control pulses
//   trigger_mode[1:0], trigger_loc[ADDR_WIDTH-1:0]  capture configuration
//   trig                         trigger comparator output (same cycle)
//   state[2:0]                   sequencer state (la_state_t encoding)
//   write_en, write_pointer      sample memory write port
//   read_pointer                 oldest valid sample address
// -----------------------------------------------------------------------------
interface la_capture_fsm_if #(
    parameter int SAMPLE_DEPTH = 1024
) ();
    import la_pkg::*;

    localparam int ADDR_WIDTH = $clog2(SAMPLE_DEPTH);

    logic                  request_start;
    logic                  request_stop;
    logic [1:0]            trigger_mode;
    logic [ADDR_WIDTH-1:0] trigger_loc;
    logic                  trig;
    logic [2:0]            state;
    logic                  write_en;
    logic [ADDR_WIDTH-1:0] write_pointer;
    logic [ADDR_WIDTH-1:0] read_pointer;

    modport master (
        output request_start,
        output request_stop,
        output trigger_mode,
        output trigger_loc,
        output trig,
        input  state,
        input  write_en,
        input  write_pointer,
        input  read_pointer
    );

    modport slave (
        input  request_start,
        input  request_stop,
        input  trigger_mode,
        input  trigger_loc,
        input  trig,
        output state,
        output write_en,
        output write_pointer,
        output read_pointer
    );

endinterface

// File: rtl/la_capture_fsm.sv
// -----------------------------------------------------------------------------
// la_capture_fsm
// Capture sequencer for the logic analyzer. Drives the sample memory write
// strobe and a circular write pointer, and tracks the oldest valid sample
// (read_pointer) so the host can unroll the buffer after capture.
//
// Modes: single-shot with programmable pre-trigger depth, immediate
// (fill the buffer unconditionally) and incremental (write only on trig).
//
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : la_capture_fsm_if.slave (requests, config, trig in;
//          state, write_en, write_pointer, read_pointer out)
//
// Parameters:
//   SAMPLE_DEPTH : number of sample memory entries (>= 2, any integer)
//   HOLDOFF      : trigger-ignore cycles after entering IN_POSITION
//                  (present only when LA_FSM_HOLDOFF_EN is defined)
//
// Build option: define LA_FSM_HOLDOFF_EN to ignore trig for HOLDOFF cycles
// after each entry to IN_POSITION.
// -----------------------------------------------------------------------------
module la_capture_fsm
    import la_pkg::*;
#(
    parameter int SAMPLE_DEPTH = 1024
`ifdef LA_FSM_HOLDOFF_EN
    ,
    parameter int HOLDOFF = 16
`endif
) (
    input logic             clk,
    input logic             rst,
    la_capture_fsm_if.slave bus
);

    localparam int ADDR_WIDTH = $clog2(SAMPLE_DEPTH);
    // One extra bit so the count can represent SAMPLE_DEPTH itself.
    localparam int CNT_W      = ADDR_WIDTH + 1;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    la_state_t             r_state;
    la_mode_t              r_mode;
    logic [ADDR_WIDTH-1:0] r_loc;
    logic [CNT_W-1:0]      r_count;
    logic [ADDR_WIDTH-1:0] r_wp;
    logic [ADDR_WIDTH-1:0] r_rp;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic                  w_write_en;
    logic                  w_trig_eff;
    logic [ADDR_WIDTH-1:0] w_wp_inc;
    logic [ADDR_WIDTH-1:0] w_rp_inc;
    logic [ADDR_WIDTH-1:0] w_loc_clamped;
    la_mode_t              w_mode_sel;
    logic                  w_move_done;
    logic                  w_full_count;

    assign w_wp_inc      = ADDR_WIDTH'(ptr_inc(32'(r_wp), SAMPLE_DEPTH));
    assign w_rp_inc      = ADDR_WIDTH'(ptr_inc(32'(r_rp), SAMPLE_DEPTH));
    assign w_loc_clamped = ADDR_WIDTH'(clamp_loc(32'(bus.trigger_loc), SAMPLE_DEPTH));
    assign w_mode_sel    = sanitize_mode(bus.trigger_mode);

    // Pre-trigger fill finishes with the write to address loc-1. Only
    // evaluated in MOVE_TO_POSITION, where loc is known to be non-zero.
    assign w_move_done   = (r_wp == r_loc - ADDR_WIDTH'(1));

    // The write happening this cycle is the SAMPLE_DEPTH-th one.
    assign w_full_count  = (r_count == CNT_W'(SAMPLE_DEPTH - 1));

`ifdef LA_FSM_HOLDOFF_EN
    localparam int HO_BITS = $clog2(HOLDOFF + 1);
    localparam int HO_W    = (HO_BITS > ADDR_WIDTH) ? HO_BITS : ADDR_WIDTH;

    logic [HO_W-1:0] r_holdoff;

    // While the holdoff counter runs the trigger is masked; sampling and
    // read_pointer advance are unaffected.
    assign w_trig_eff = bus.trig && (r_holdoff == '0);
`else
    assign w_trig_eff = bus.trig;
`endif

    // Write strobe depends only on registered state and the same-cycle trig
    // so that request_* never reaches the memory write port combinationally.
    always_comb begin
        w_write_en = 1'b0;
        case (r_state)
            MOVE_TO_POSITION,
            IN_POSITION:      w_write_en = 1'b1;
            CAPTURING:        w_write_en = (r_mode == INCREMENTAL) ? bus.trig : 1'b1;
            default:          w_write_en = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mode    <= SINGLE_SHOT;
            r_loc     <= '0;
            r_count   <= '0;
            r_wp      <= '0;
            r_rp      <= '0;
`ifdef LA_FSM_HOLDOFF_EN
            r_holdoff <= '0;
`endif
        end else if (bus.request_stop) begin
            // Abort from anywhere; pointers stay where they are so the host
            // can still inspect a partial capture. Stop outranks start.
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE,
                CAPTURED: begin
                    if (bus.request_start) begin
                        r_wp    <= '0;
                        r_rp    <= '0;
                        r_count <= '0;
                        r_mode  <= w_mode_sel;
                        r_loc   <= w_loc_clamped;
                        if (w_mode_sel == SINGLE_SHOT) begin
                            if (w_loc_clamped == '0) begin
                                r_state <= IN_POSITION;
`ifdef LA_FSM_HOLDOFF_EN
                                r_holdoff <= HO_W'(HOLDOFF);
`endif
                            end else begin
                                r_state <= MOVE_TO_POSITION;
                            end
                        end else begin
                            r_state <= CAPTURING;
                        end
                    end
                end

                MOVE_TO_POSITION: begin
                    // Fill the pre-trigger region; trig is deliberately unused.
                    r_wp <= w_wp_inc;
                    if (w_move_done) begin
                        r_state <= IN_POSITION;
`ifdef LA_FSM_HOLDOFF_EN
                        r_holdoff <= HO_W'(HOLDOFF);
`endif
                    end
                end

                IN_POSITION: begin
                    r_wp <= w_wp_inc;
`ifdef LA_FSM_HOLDOFF_EN
                    if (r_holdoff != '0) begin
                        r_holdoff <= r_holdoff - HO_W'(1);
                    end
`endif
                    if (w_trig_eff) begin
                        // This write is the trigger sample; the oldest
                        // pre-trigger sample is now pinned.
                        r_state <= CAPTURING;
                    end else begin
                        // Slide the window to keep exactly loc samples
                        // behind the write pointer.
                        r_rp <= w_rp_inc;
                    end
                end

                CAPTURING: begin
                    if (w_write_en) begin
                        r_wp    <= w_wp_inc;
                        r_count <= r_count + CNT_W'(1);
                        if (r_mode == SINGLE_SHOT) begin
                            // Buffer is full when the writer catches up with
                            // the oldest retained sample.
                            if (w_wp_inc == r_rp) begin
                                r_state <= CAPTURED;
                            end
                        end else if (w_full_count) begin
                            // Immediate and incremental both start at 0 with
                            // read_pointer=0, so wp==rp cannot mark the end;
                            // count writes instead.
                            r_state <= CAPTURED;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.state         = r_state;
    assign bus.write_en      = w_write_en;
    assign bus.write_pointer = r_wp;
    assign bus.read_pointer  = r_rp;

endmodule
